id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with hazard logic for the 5-stage RV32I core.
- Captures decode outputs and the two register-file read operands each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and by load-use stall bubbles.
- Drives forwarded operands and control into the EX stage; raises stall toward PC/IF-ID.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width

Ports:
clk  in  1  pipeline clock, all state on posedge
rst  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_pc  in  XLEN  decode PC
id_rs1, id_rs2  in  REG_AW  source register addresses (same values driven to reg file A1/A2)
id_rd  in  REG_AW  destination register
id_imm  in  XLEN  sign-extended immediate
id_reg_write, id_mem_read, id_mem_write, id_alu_src  in  1 each  decode controls
id_alu_op  in  4  ALU operation
rd1, rd2  in  XLEN  register-file read data (x0 already reads 0)
flush  in  1  branch/jump taken in EX; kill the decode slot
exm_rd  in  REG_AW  EX/MEM destination
exm_reg_write  in  1  EX/MEM writes rd
exm_result  in  XLEN  EX/MEM ALU result
mwb_rd  in  REG_AW  MEM/WB destination (also reg file A3)
mwb_reg_write  in  1  MEM/WB writes rd (also WE3)
mwb_result  in  XLEN  MEM/WB write-back data (also WD3)
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX slot valid
ex_pc, ex_imm  out  XLEN  registered
ex_rd  out  REG_AW  registered
ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered, forced 0 when ex_valid=0
ex_alu_op  out  4  registered
ex_op_a  out  XLEN  forwarded rs1 value
ex_op_b  out  XLEN  ALU operand B: ex_imm if ex_alu_src, else forwarded rs2
ex_store_data  out  XLEN  forwarded rs2 value, always

Behaviour:
- Reset (rst=0, asynchronous): all registered state is 0, including ex_valid; stall=0.
- Registered state: valid, pc, imm, rs1, rs2, rd, the control bits, rs1_val, rs2_val.
- Load-use detect: stall=1 iff ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd). Both rs fields are compared regardless of format.
- Flush priority: flush=1 forces stall=0.
- Posedge update, highest priority first:
  1. flush or stall: bubble (valid=0, all controls 0); data fields don't-care.
  2. Otherwise: capture all id_* fields, rd1, rd2; valid=id_valid. Controls are ANDed with id_valid.
- Forwarding (combinational, per operand, on the registered rs/value):
  - If exm_reg_write & exm_rd!=0 & exm_rd==rs: use exm_result.
  - Else if mwb_reg_write & mwb_rd!=0 & mwb_rd==rs: use mwb_result.
  - Else: use the captured value.
  - EX/MEM wins when both match.
- Write-back same-cycle read: the reg file writes on negedge, so rd1/rd2 captured at posedge already reflect a MEM/WB write in the same cycle. No bypass of rd1/rd2 is added here.
- x0: rs==0 never forwards; operand stays as captured (0).
- Latency: 1 cycle ID to EX; forwarding adds 0 cycles.
- Load-use costs exactly one bubble. Next cycle the load is in MEM, and its data is forwarded as mwb_result one cycle later via the MEM/WB path.
- Reset mid-operation clears the in-flight instruction; no partial state survives.

Optional Feature:
- Macro: IDEX_FWD_EN.
- Defined: forwarding as above.
- Undefined: the forwarding muxes are removed and operands come straight from captured values.
  - stall=1 when id_valid & rs!=0 & the rs matches a writing rd in the EX slot (ex_valid & ex_reg_write & ex_rd) or in EX/MEM (exm_reg_write & exm_rd).
  - MEM/WB needs no stall because of the negedge write.
  - Stalls last up to 2 cycles; flush still overrides.

Test Plan:
- Reset then release; id_valid=0 -> ex_valid=0, all ex_* controls 0, stall=0.
- add x5 (EX/MEM result 0x10), next instr add x6,x5,x5 with rd1=rd2=0 -> ex_op_a=ex_store_data=0x10.
- EX/MEM rd=x7 result 0xAA and MEM/WB rd=x7 result 0xBB, EX reads x7 -> ex_op_a=0xAA.
- lw x9 in EX, decode add x1,x9,x0 -> stall=1 one cycle, bubble ex_valid=0; next cycle forwards mwb_result=0x20.
- Stall condition plus flush=1 in the same cycle -> stall=0, ex_valid=0 next cycle.
- Writes to x0 with result 0xFFFF_FFFF, EX reads x0 -> ex_op_a=0. Without IDEX_FWD_EN, add after add on x5 -> stall 2 cycles, then operand equals rd1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core: captures decode outputs, detects RAW hazards, drives EX operands.
// Build option IDEX_FWD_EN: EX/MEM and MEM/WB forwarding. Undefined: no forwarding, RAW hazards stall instead.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_op,
    input  logic [XLEN-1:0]   rd1,
    input  logic [XLEN-1:0]   rd2,
    input  logic              flush,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic              mwb_reg_write,
    input  logic [XLEN-1:0]   mwb_result,
    output logic              stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic [3:0]        ex_alu_op,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [XLEN-1:0]   ex_store_data
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    logic              valid_r;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   imm_r;
    logic [REG_AW-1:0] rs1_r;
    logic [REG_AW-1:0] rs2_r;
    logic [REG_AW-1:0] rd_r;
    logic              reg_write_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              alu_src_r;
    logic [3:0]        alu_op_r;
    logic [XLEN-1:0]   rs1_val_r;
    logic [XLEN-1:0]   rs2_val_r;

    logic              load_use_s;
    logic              hazard_s;
    logic              stall_s;
    logic [XLEN-1:0]   fwd_a_s;
    logic [XLEN-1:0]   fwd_b_s;

`ifdef IDEX_FWD_EN
    // EX/MEM is younger than MEM/WB, so it wins when both write the same register
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   captured,
        input logic              e_we,
        input logic [REG_AW-1:0] e_rd,
        input logic [XLEN-1:0]   e_res,
        input logic              m_we,
        input logic [REG_AW-1:0] m_rd,
        input logic [XLEN-1:0]   m_res
    );
        logic [XLEN-1:0] sel;
        if (e_we && (e_rd != REG_ZERO) && (e_rd == rs)) begin
            sel = e_res;
        end else if (m_we && (m_rd != REG_ZERO) && (m_rd == rs)) begin
            sel = m_res;
        end else begin
            sel = captured;
        end
        return sel;
    endfunction
`else
    // A producer still in EX or EX/MEM has not written the register file yet
    function automatic logic raw_dep(
        input logic [REG_AW-1:0] rs,
        input logic              ex_we,
        input logic [REG_AW-1:0] ex_dst,
        input logic              e_we,
        input logic [REG_AW-1:0] e_rd
    );
        return (rs != REG_ZERO) && ((ex_we && (ex_dst == rs)) || (e_we && (e_rd == rs)));
    endfunction

    logic unused_fwd_s;
    assign unused_fwd_s = ^{exm_result, mwb_rd, mwb_reg_write, mwb_result, rs1_r, rs2_r};
`endif

    // Hazard detection; flush and reset suppress the stall
    always_comb begin
        load_use_s = 1'b0;
        hazard_s   = 1'b0;
        stall_s    = 1'b0;
        if (valid_r && mem_read_r && (rd_r != REG_ZERO) && id_valid &&
            ((id_rs1 == rd_r) || (id_rs2 == rd_r))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
`ifdef IDEX_FWD_EN
        hazard_s = load_use_s;
`else
        hazard_s = load_use_s |
                   (id_valid & (raw_dep(id_rs1, valid_r & reg_write_r, rd_r, exm_reg_write, exm_rd) |
                                raw_dep(id_rs2, valid_r & reg_write_r, rd_r, exm_reg_write, exm_rd)));
`endif
        if (!rst || flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = hazard_s;
        end
    end

    // Operand selection for the instruction in EX
    always_comb begin
        fwd_a_s = rs1_val_r;
        fwd_b_s = rs2_val_r;
`ifdef IDEX_FWD_EN
        fwd_a_s = fwd_sel(rs1_r, rs1_val_r, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_result);
        fwd_b_s = fwd_sel(rs2_r, rs2_val_r, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_result);
`endif
    end

    // Pipeline register: bubble on flush/stall, otherwise capture the decode slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r     <= 1'b0;
            pc_r        <= {XLEN{1'b0}};
            imm_r       <= {XLEN{1'b0}};
            rs1_r       <= REG_ZERO;
            rs2_r       <= REG_ZERO;
            rd_r        <= REG_ZERO;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            alu_src_r   <= 1'b0;
            alu_op_r    <= 4'd0;
            rs1_val_r   <= {XLEN{1'b0}};
            rs2_val_r   <= {XLEN{1'b0}};
        end else if (flush || stall_s) begin
            valid_r     <= 1'b0;
            pc_r        <= {XLEN{1'b0}};
            imm_r       <= {XLEN{1'b0}};
            rs1_r       <= REG_ZERO;
            rs2_r       <= REG_ZERO;
            rd_r        <= REG_ZERO;
            reg_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            alu_src_r   <= 1'b0;
            alu_op_r    <= 4'd0;
            rs1_val_r   <= {XLEN{1'b0}};
            rs2_val_r   <= {XLEN{1'b0}};
        end else begin
            valid_r     <= id_valid;
            pc_r        <= id_pc;
            imm_r       <= id_imm;
            rs1_r       <= id_rs1;
            rs2_r       <= id_rs2;
            rd_r        <= id_rd;
            reg_write_r <= id_reg_write & id_valid;
            mem_read_r  <= id_mem_read & id_valid;
            mem_write_r <= id_mem_write & id_valid;
            alu_src_r   <= id_alu_src & id_valid;
            alu_op_r    <= id_alu_op;
            rs1_val_r   <= rd1;
            rs2_val_r   <= rd2;
        end
    end

    assign stall         = stall_s;
    assign ex_valid      = valid_r;
    assign ex_pc         = pc_r;
    assign ex_imm        = imm_r;
    assign ex_rd         = rd_r;
    assign ex_reg_write  = reg_write_r;
    assign ex_mem_read   = mem_read_r;
    assign ex_mem_write  = mem_write_r;
    assign ex_alu_src    = alu_src_r;
    assign ex_alu_op     = alu_op_r;
    assign ex_op_a       = fwd_a_s;
    assign ex_store_data = fwd_b_s;
    assign ex_op_b       = alu_src_r ? imm_r : fwd_b_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios, then random traffic against a slot-level model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_imm, rd1, rd2, exm_result, mwb_result;
    logic [4:0]  id_rs1, id_rs2, id_rd, exm_rd, mwb_rd;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic [3:0]  id_alu_op;
    logic        flush, exm_reg_write, mwb_reg_write;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [31:0] ex_pc, ex_imm, ex_op_a, ex_op_b, ex_store_data;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;

    int checks = 0;
    int errors = 0;
    logic [31:0] pc_ctr = 32'h0000_0100;

    // Instruction currently occupying the EX slot, as the architecture sees it
    typedef struct packed {
        logic        v;
        logic [31:0] pc, imm, a, b;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, as;
        logic [3:0]  op;
    } slot_t;
    slot_t m;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .rd1(rd1), .rd2(rd2),
        .flush(flush), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_store_data(ex_store_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value the EX stage should use for a source register given what is in flight
    function automatic logic [31:0] oper(input logic [4:0] rs, input logic [31:0] v);
`ifdef IDEX_FWD_EN
        if (rs != 5'd0 && exm_reg_write && exm_rd == rs) return exm_result;
        if (rs != 5'd0 && mwb_reg_write && mwb_rd == rs) return mwb_result;
`endif
        return v;
    endfunction

`ifndef IDEX_FWD_EN
    function automatic logic pending(input logic [4:0] r);
        return (r != 5'd0) && ((m.v && m.rw && m.rd == r) || (exm_reg_write && exm_rd == r));
    endfunction
`endif

    function automatic logic exp_stall();
        logic lu, raw;
        if (!rst || flush || !id_valid) return 1'b0;
        lu = m.v && m.mr && (m.rd != 5'd0) && (id_rs1 == m.rd || id_rs2 == m.rd);
`ifdef IDEX_FWD_EN
        raw = 1'b0;
`else
        raw = pending(id_rs1) || pending(id_rs2);
`endif
        return lu || raw;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] st;
        chk({tag, "/stall"}, {31'd0, stall}, {31'd0, exp_stall()});
        chk({tag, "/valid"}, {31'd0, ex_valid}, {31'd0, m.v});
        chk({tag, "/ctrl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src},
            {28'd0, m.rw, m.mr, m.mw, m.as});
        if (m.v) begin
            st = oper(m.rs2, m.b);
            chk({tag, "/pc"}, ex_pc, m.pc);
            chk({tag, "/imm"}, ex_imm, m.imm);
            chk({tag, "/rd_op"}, {23'd0, ex_rd, ex_alu_op}, {23'd0, m.rd, m.op});
            chk({tag, "/op_a"}, ex_op_a, oper(m.rs1, m.a));
            chk({tag, "/store"}, ex_store_data, st);
            chk({tag, "/op_b"}, ex_op_b, m.as ? m.imm : st);
        end
    endtask

    // Check the current cycle, then advance one clock and update the model
    task automatic step(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        if (!rst || flush || exp_stall()) begin
            m = '0;
        end else begin
            m.v = id_valid; m.pc = id_pc; m.imm = id_imm; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.rw = id_reg_write & id_valid; m.mr = id_mem_read & id_valid;
            m.mw = id_mem_write & id_valid; m.as = id_alu_src & id_valid;
            m.op = id_alu_op; m.a = rd1; m.b = rd2;
        end
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic rw, input logic mr, input logic [31:0] a, input logic [31:0] b);
        id_valid = v; id_rs1 = s1; id_rs2 = s2; id_rd = d; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = 1'b0; id_alu_src = 1'b0; id_alu_op = 4'd0; rd1 = a; rd2 = b;
        id_pc = pc_ctr; pc_ctr = pc_ctr + 32'd4; id_imm = $urandom;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ev,
                           input logic mw, input logic [4:0] mr, input logic [31:0] mv);
        exm_reg_write = ew; exm_rd = er; exm_result = ev;
        mwb_reg_write = mw; mwb_rd = mr; mwb_result = mv;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; m = '0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        step("idle");

        // add x5 followed by add x6,x5,x5
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'h3, 32'h4);
        step("add_x5");
        set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 32'h0, 32'h0);
        step("raw_c1");
        set_fwd(1'b1, 5'd5, 32'h10, 1'b0, 5'd0, 32'd0);
        step("raw_c2");
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h10);
        rd1 = 32'h10; rd2 = 32'h10;
        step("raw_c3");
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("x6_op_a", ex_op_a, 32'h10);
        chk("x6_store", ex_store_data, 32'h10);
        step("raw_c4");

        // EX/MEM and MEM/WB both target x7
        set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'h55, 32'h0);
        step("x7_c1");
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_fwd(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
        step("x7_c2");

        // lw x9 then add x1,x9,x0
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0);
        step("lu_c0");
        set_id(1'b1, 5'd9, 5'd0, 5'd1, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk("lu_stall", {31'd0, stall}, 32'd1);
        step("lu_c1");
        set_fwd(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0, 32'd0);
        #1;
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step("lu_c2");
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h20);
        rd1 = 32'h20;
        step("lu_c3");
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        chk("lu_op_a", ex_op_a, 32'h20);
        step("lu_c4");

        // Load-use hazard coinciding with flush
        set_id(1'b1, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 32'h0, 32'h0);
        step("fl_lw");
        set_id(1'b1, 5'd9, 5'd0, 5'd1, 1'b1, 1'b0, 32'h0, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        step("fl_c1");
        flush = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("flush_bubble", {31'd0, ex_valid}, 32'd0);
        step("fl_c2");

        // Writers targeting x0 must never reach an x0 read
        set_id(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 32'h0, 32'h0);
        step("x0_c1");
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_fwd(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        chk("x0_op_a", ex_op_a, 32'h0);
        chk("x0_store", ex_store_data, 32'h0);
        step("x0_c2");

        // Reset with a valid instruction in flight
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h5, 32'h6);
        step("pre_rst");
        rst = 1'b0;
        m = '0;
        step("rst_mid");
        rst = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("post_rst");

        // Random traffic with a small register window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            id_valid = ($urandom_range(3, 0) != 0);
            id_pc = $urandom; id_imm = $urandom; rd1 = $urandom; rd2 = $urandom;
            id_rs1 = 5'($urandom_range(7, 0)); id_rs2 = 5'($urandom_range(7, 0));
            id_rd = 5'($urandom_range(7, 0));
            id_reg_write = 1'($urandom_range(1, 0)); id_mem_read = 1'($urandom_range(1, 0));
            id_mem_write = 1'($urandom_range(1, 0)); id_alu_src = 1'($urandom_range(1, 0));
            id_alu_op = 4'($urandom_range(15, 0));
            flush = ($urandom_range(9, 0) == 0);
            set_fwd(1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom,
                    1'($urandom_range(1, 0)), 5'($urandom_range(7, 0)), $urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
